// File: rtl/vpu_pkg.sv
// Shared VPU constants and the register-file write request payload.
package vpu_pkg;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned VLEN   = 64;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BWEB_W = VLEN / 8;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MUL = 1;
    localparam int unsigned REQ_LSU = 2;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [BWEB_W-1:0] bweb;
        logic [VLEN-1:0]   data;
        logic              last;
    } vreg_wreq_t;

endpackage

// File: rtl/vpu_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module vpu_rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] valid_i,
    output logic [NREQ-1:0] gnt_c_o
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] sel_c;
    logic             found_c;

    // Two passes: first requesters at or above the pointer, then wrap to the bottom.
    always_comb begin
        gnt_c_o = '0;
        sel_c   = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_c && valid_i[i] && (i >= 32'(ptr_q))) begin
                found_c    = 1'b1;
                sel_c      = PTR_W'(i);
                gnt_c_o[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_c && valid_i[i]) begin
                found_c    = 1'b1;
                sel_c      = PTR_W'(i);
                gnt_c_o[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found_c) begin
            ptr_d = (sel_c == PTR_W'(NREQ - 1)) ? '0 : sel_c + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vpu_vreg_write_arbiter.sv
// Shares the vector regfile write port among ALU/MUL/LSU and tracks pending writes per register.
module vpu_vreg_write_arbiter
    import vpu_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NREQ-1:0]               req_valid_i,
    output logic [NREQ-1:0]               req_ready_o,
    input  logic [NREQ-1:0][REG_AW-1:0]   req_addr_i,
    input  logic [NREQ-1:0][BWEB_W-1:0]   req_bweb_i,
    input  logic [NREQ-1:0][VLEN-1:0]     req_data_i,
    input  logic [NREQ-1:0]               req_last_i,
    input  logic                          issue_valid_i,
    input  logic [REG_AW-1:0]             issue_vd_i,
    output logic                          vreg_write_en_o,
    output logic [REG_AW-1:0]             vreg_write_addr_o,
    output logic [BWEB_W-1:0]             vreg_write_bweb_o,
    output logic [VLEN-1:0]               vreg_write_data_o,
    output logic [NREG-1:0]               vreg_busy_o
);

    logic [NREQ-1:0] arb_valid_c;
    logic [NREQ-1:0] gnt_c;
    vreg_wreq_t      wreq_q, wreq_d;
    logic            wen_q, wen_d;
    logic [NREG-1:0] busy_q, busy_d;

    // No grants while reset is asserted so requesters re-present afterwards.
    assign arb_valid_c = req_valid_i & {NREQ{rst_ni}};

    vpu_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (arb_valid_c),
        .gnt_c_o (gnt_c)
    );

    assign req_ready_o = gnt_c;

    // Capture the winner's payload; hold the last payload when nothing is granted.
    always_comb begin
        wen_d  = |gnt_c;
        wreq_d = wreq_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                wreq_d.addr = req_addr_i[i];
                wreq_d.bweb = req_bweb_i[i];
                wreq_d.data = req_data_i[i];
                wreq_d.last = req_last_i[i];
            end
        end
    end

    // Clear on the committing last write, then set from issue so a new writer wins.
    always_comb begin
        busy_d = busy_q;
        if (wen_q && wreq_q.last) begin
            busy_d[wreq_q.addr] = 1'b0;
        end
        if (issue_valid_i) begin
            busy_d[issue_vd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wen_q  <= 1'b0;
            wreq_q <= '0;
            busy_q <= '0;
        end else begin
            wen_q  <= wen_d;
            wreq_q <= wreq_d;
            busy_q <= busy_d;
        end
    end

    assign vreg_write_en_o   = wen_q;
    assign vreg_write_addr_o = wreq_q.addr;
    assign vreg_write_bweb_o = wreq_q.bweb;
    assign vreg_write_data_o = wreq_q.data;
    assign vreg_busy_o       = busy_q;

endmodule

// File: tb/tb_vpu_vreg_write_arbiter.sv
// Directed bench for the vector regfile write arbiter and pending-write scoreboard.
module tb_vpu_vreg_write_arbiter;
    import vpu_pkg::*;

    logic                        clk;
    logic                        rst_n;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][REG_AW-1:0] req_addr;
    logic [NREQ-1:0][BWEB_W-1:0] req_bweb;
    logic [NREQ-1:0][VLEN-1:0]   req_data;
    logic [NREQ-1:0]             req_last;
    logic                        issue_valid;
    logic [REG_AW-1:0]           issue_vd;
    logic                        wr_en;
    logic [REG_AW-1:0]           wr_addr;
    logic [BWEB_W-1:0]           wr_bweb;
    logic [VLEN-1:0]             wr_data;
    logic [NREG-1:0]             busy;

    int n_tests = 0;
    int n_fail  = 0;

    vpu_vreg_write_arbiter dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_i        (req_addr),
        .req_bweb_i        (req_bweb),
        .req_data_i        (req_data),
        .req_last_i        (req_last),
        .issue_valid_i     (issue_valid),
        .issue_vd_i        (issue_vd),
        .vreg_write_en_o   (wr_en),
        .vreg_write_addr_o (wr_addr),
        .vreg_write_bweb_o (wr_bweb),
        .vreg_write_data_o (wr_data),
        .vreg_busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 3'b111;
        issue_valid = 1'b0;
        issue_vd    = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = REG_AW'(10 + i);
            req_bweb[i] = 8'hFF;
            req_data[i] = 64'h1000 + 64'(i);
            req_last[i] = 1'b0;
        end

        // Reset held for two edges with every requester valid.
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_en",    64'(wr_en),     64'h0);
        chk("rst_busy",  64'(busy),      64'h0);
        tick();
        rst_n = 1'b1;

        // Round-robin: 0,1,2,0,1,2 with writes trailing by one cycle.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
            if (k == 0) begin
                chk("rr_en0", 64'(wr_en), 64'h0);
            end else begin
                chk("rr_en",   64'(wr_en),   64'h1);
                chk("rr_addr", 64'(wr_addr), 64'(10 + ((k - 1) % 3)));
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_tail_en",    64'(wr_en),     64'h1);
        chk("rr_tail_addr",  64'(wr_addr),   64'd12);
        chk("idle_ready",    64'(req_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("idle_en",       64'(wr_en),     64'h0);
        chk("idle_addr_hold", 64'(wr_addr),  64'd12);
        tick();

        // Single MUL write to v5 after issuing v5.
        issue_valid = 1'b1;
        issue_vd    = 5'd5;
        tick();
        issue_valid          = 1'b0;
        req_valid            = 3'b010;
        req_addr[REQ_MUL]    = 5'd5;
        req_bweb[REQ_MUL]    = 8'hFF;
        req_data[REQ_MUL]    = 64'hDEADBEEF_01234567;
        req_last[REQ_MUL]    = 1'b1;
        @(negedge clk);
        chk("sw_busy_set", 64'(busy),      64'h20);
        chk("sw_ready",    64'(req_ready), 64'(3'b010));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("sw_en",        64'(wr_en),   64'h1);
        chk("sw_addr",      64'(wr_addr), 64'd5);
        chk("sw_data",      wr_data,      64'hDEADBEEF_01234567);
        chk("sw_bweb",      64'(wr_bweb), 64'hFF);
        chk("sw_busy_hold", 64'(busy),    64'h20);
        tick();
        @(negedge clk);
        chk("sw_busy_clr", 64'(busy),  64'h0);
        chk("sw_en_off",   64'(wr_en), 64'h0);

        // Collision: re-issue v7 while its last write commits; pointer is at 2 here.
        issue_valid       = 1'b1;
        issue_vd          = 5'd7;
        req_valid         = 3'b001;
        req_addr[REQ_ALU] = 5'd7;
        req_last[REQ_ALU] = 1'b1;
        @(negedge clk);
        chk("col_ready_wrap", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("col_en",   64'(wr_en),   64'h1);
        chk("col_addr", 64'(wr_addr), 64'd7);
        chk("col_busy", 64'(busy),    64'h80);
        tick();
        issue_valid = 1'b0;
        req_valid   = 3'b001;
        @(negedge clk);
        chk("col_set_wins", 64'(busy),      64'h80);
        chk("col_ready2",   64'(req_ready), 64'(3'b001));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("col_en2", 64'(wr_en), 64'h1);
        tick();
        issue_valid = 1'b1;
        issue_vd    = 5'd8;
        @(negedge clk);
        chk("col_busy_clr", 64'(busy), 64'h0);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("issue_v8", 64'(busy), 64'h0000_0100);

        // Multi-beat LSU to v3: only the 4th beat carries last.
        tick();
        issue_valid = 1'b1;
        issue_vd    = 5'd3;
        tick();
        issue_valid       = 1'b0;
        req_valid         = 3'b100;
        req_addr[REQ_LSU] = 5'd3;
        req_bweb[REQ_LSU] = 8'hFF;
        req_data[REQ_LSU] = 64'hA1;
        req_last[REQ_LSU] = 1'b0;
        @(negedge clk);
        chk("mb_b1_busy",  64'(busy),      64'h108);
        chk("mb_b1_ready", 64'(req_ready), 64'(3'b100));
        tick();
        req_bweb[REQ_LSU] = 8'h00;
        req_data[REQ_LSU] = 64'hA2;
        @(negedge clk);
        chk("mb_b2_en",   64'(wr_en), 64'h1);
        chk("mb_b2_busy", 64'(busy),  64'h108);
        tick();
        req_bweb[REQ_LSU] = 8'hFF;
        req_data[REQ_LSU] = 64'hA3;
        @(negedge clk);
        chk("mb_zero_bweb_en", 64'(wr_en),   64'h1);
        chk("mb_zero_bweb",    64'(wr_bweb), 64'h00);
        chk("mb_b3_busy",      64'(busy),    64'h108);
        tick();
        req_data[REQ_LSU] = 64'hA4;
        req_last[REQ_LSU] = 1'b1;
        @(negedge clk);
        chk("mb_b4_ready", 64'(req_ready), 64'(3'b100));
        chk("mb_b4_busy",  64'(busy),      64'h108);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("mb_last_en",   64'(wr_en),   64'h1);
        chk("mb_last_data", wr_data,      64'hA4);
        chk("mb_last_busy", 64'(busy),    64'h108);
        tick();
        @(negedge clk);
        chk("mb_busy_clr", 64'(busy), 64'h100);

        // Mid-operation reset: ALU grant moves pointer to 1, reset must return it to 0.
        req_valid         = 3'b001;
        req_addr[REQ_ALU] = 5'd9;
        req_last[REQ_ALU] = 1'b0;
        @(negedge clk);
        chk("mr_ready", 64'(req_ready), 64'(3'b001));
        tick();
        rst_n     = 1'b0;
        req_valid = 3'b111;
        @(negedge clk);
        chk("mr_en_reg",   64'(wr_en),     64'h1);
        chk("mr_ready_rst", 64'(req_ready), 64'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_en_drop", 64'(wr_en),     64'h0);
        chk("mr_busy",    64'(busy),      64'h0);
        chk("mr_ptr0",    64'(req_ready), 64'(3'b001));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vpu_vreg_write_arbiter.md
Name: vpu_vreg_write_arbiter

Overview:
- Shares the single write port of the VPU vector register file among three result producers: ALU (0), MUL/DIV (1) and LSU (2).
- Arbitration is round-robin with valid/ready handshakes. The winning request is registered onto the regfile write port.
- Keeps a per-register pending scoreboard. The issue stage sets an entry at dispatch; it clears when the producer's final write commits. The issue stage uses this for RAW/WAW stalls.

Parameters:
- NREQ, 3, number of write requesters (fixed order: 0 ALU, 1 MUL/DIV, 2 LSU)
- VLEN, 64, vector register width in bits
- NREG, 32, number of architectural vector registers

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  NREQ  per-requester write request valid
- req_ready_o  out  NREQ  per-requester grant/accept
- req_addr_i  in  NREQ x 5  destination register
- req_bweb_i  in  NREQ x VLEN/8  byte write enables
- req_data_i  in  NREQ x VLEN  write data
- req_last_i  in  NREQ  final write of this instruction (clears pending)
- issue_valid_i  in  1  instruction dispatched with a vector destination
- issue_vd_i  in  5  its destination register
- vreg_write_en_o  out  1  to regfile write enable
- vreg_write_addr_o  out  5  to regfile write address
- vreg_write_bweb_o  out  VLEN/8  to regfile byte enables
- vreg_write_data_o  out  VLEN  to regfile write data
- vreg_busy_o  out  NREG  pending-write mask per register

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - all outputs are 0
  - priority pointer is 0
  - scoreboard cleared
  - any request in the output register is dropped
  - requesters must re-present after reset
- Handshake:
  - A transfer occurs when req_valid_i[i] && req_ready_o[i].
  - valid must not depend on ready. Once raised, valid and payload are held until accepted.
  - req_ready_o is combinational from req_valid_i and the pointer. It is one-hot or zero.
  - req_ready_o[i] is never high when req_valid_i[i] is low.
- Arbitration:
  - Search starts at the pointer and runs upward modulo NREQ. The first valid requester is granted.
  - At most one grant per cycle. The regfile never stalls, so a grant is issued in every cycle where any valid is high.
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Write path:
  - Latency is 1 cycle. The granted payload is registered. vreg_write_en_o is high in the cycle after acceptance, with the captured addr/bweb/data.
  - vreg_write_en_o is 0 in cycles that follow a cycle with no grant. Output addr/bweb/data are don't-care then, but are held.
  - bweb of all zeros is still a valid write: en=1, and the regfile writes nothing.
  - Back-to-back grants produce back-to-back writes (full throughput).
- Scoreboard:
  - issue_valid_i sets vreg_busy_o[issue_vd_i] at the next edge.
  - A cycle with vreg_write_en_o high and a registered last flag clears vreg_busy_o[vreg_write_addr_o] at the end of that cycle. This is the same edge on which the regfile commits, so a reader sees not-busy only when the data is current.
  - Set and clear of the same register on the same edge: set wins, because a new writer is in flight.
  - Clear of a register that is not busy: no effect.
  - Issue to a register that is already busy: it stays busy. Preventing a second writer is the issue stage's responsibility, as it stalls on vreg_busy_o.
- Non-last writes (multi-beat LSU/segment ops) do not touch the scoreboard.

Decomposition:
- vpu_pkg holds:
  - VLEN, NREG
  - the requester index constants REQ_ALU=0, REQ_MUL=1, REQ_LSU=2
  - struct vreg_wreq_t {addr, bweb, data, last}, used for both request inputs and the output register
- One sub-module is natural: vpu_rr_arbiter (parameterised NREQ, valid vector in, one-hot grant out, internal pointer, advance on grant). It is reusable for read-port sharing later.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with all valids high -> ready=0, write_en=0, busy=0. First cycle after release grants ALU (ready=3'b001).
- Single write: MUL valid, addr=5, bweb=8'hFF, data=64'hDEADBEEF_01234567, last=1, with vd=5 previously issued -> ready[1] same cycle; next cycle en=1, addr=5, that data; busy[5] reads 0 the cycle after.
- Round-robin fairness: all three valid continuously for 6 cycles -> grants 0,1,2,0,1,2; writes follow one cycle later with no bubbles.
- Collision: issue_vd=7 in the same cycle that the last write to v7 commits -> busy[7]=1 afterwards. Issue vd=8 with no writes -> busy=32'h0000_0100.
- Multi-beat LSU: 4 writes to v3 with last only on the 4th, ALU idle -> busy[3] stays 1 through beats 1-3 and drops after beat 4 commits.
- Mid-operation reset: assert rst_ni=0 while a grant is registered -> write_en=0 next cycle, scoreboard 0, pointer 0.
